// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_pkg
// Brief    : Shared widths, ALU command encodings and control bundle for the
//            ID/EX pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

    localparam int DEF_WORD_LEN     = 32;
    localparam int DEF_REG_ADDR_LEN = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_cmd_e;

    typedef struct packed {
        logic [2:0] alu_cmd;
        logic       alu_src_imm;
        logic       mem_read;
        logic       mem_write;
        logic       wb_en;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{alu_cmd: ALU_ADD, alu_src_imm: 1'b0,
                                   mem_read: 1'b0, mem_write: 1'b0, wb_en: 1'b0};

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_fwd_mux
// Brief    : Per-operand RAW bypass select, MEM over WB, register 0 never
//            bypassed. FWD_EN=0 passes the registered value straight through.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage_fwd_mux #(
   parameter int WORD_LEN     = 32,
   parameter int REG_ADDR_LEN = 5,
   parameter bit FWD_EN       = 1'b1
) (
   input  logic [REG_ADDR_LEN-1:0] src_idx,
   input  logic [WORD_LEN-1:0]     reg_val,
   input  logic                    mem_wb_en,
   input  logic [REG_ADDR_LEN-1:0] mem_dest,
   input  logic [WORD_LEN-1:0]     mem_val,
   input  logic                    wb_wb_en,
   input  logic [REG_ADDR_LEN-1:0] wb_dest,
   input  logic [WORD_LEN-1:0]     wb_val,
   output logic [WORD_LEN-1:0]     fwd_val
);

   always_comb begin
      fwd_val = reg_val;
      if (FWD_EN && (src_idx != '0)) begin
         if (mem_wb_en && (mem_dest == src_idx)) begin
            fwd_val = mem_val;
         end else if (wb_wb_en && (wb_dest == src_idx)) begin
            fwd_val = wb_val;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register feeding the ALU, with MEM/WB forwarding
//            and load-use detection. Optional: ID_EX_FORWARDING_EN.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int WORD_LEN     = DEF_WORD_LEN,
   parameter int REG_ADDR_LEN = DEF_REG_ADDR_LEN
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    stall,
   input  logic                    flush,
   input  logic                    id_valid,
   input  logic [WORD_LEN-1:0]     id_reg1_data,
   input  logic [WORD_LEN-1:0]     id_reg2_data,
   input  logic [WORD_LEN-1:0]     id_imm,
   input  logic [REG_ADDR_LEN-1:0] id_rs,
   input  logic [REG_ADDR_LEN-1:0] id_rt,
   input  logic [REG_ADDR_LEN-1:0] id_dest,
   input  logic [2:0]              id_alu_cmd,
   input  logic                    id_alu_src_imm,
   input  logic                    id_mem_read,
   input  logic                    id_mem_write,
   input  logic                    id_wb_en,
   input  logic                    mem_wb_en,
   input  logic [REG_ADDR_LEN-1:0] mem_dest,
   input  logic [WORD_LEN-1:0]     mem_alu_result,
   input  logic                    wb_wb_en,
   input  logic [REG_ADDR_LEN-1:0] wb_dest,
   input  logic [WORD_LEN-1:0]     wb_value,
   output logic                    ex_valid,
   output logic [WORD_LEN-1:0]     ex_alu_a,
   output logic [WORD_LEN-1:0]     ex_alu_b,
   output logic [2:0]              ex_alu_cmd,
   output logic [WORD_LEN-1:0]     ex_store_data,
   output logic [REG_ADDR_LEN-1:0] ex_dest,
   output logic                    ex_mem_read,
   output logic                    ex_mem_write,
   output logic                    ex_wb_en,
   output logic                    load_use_hazard
);

`ifdef ID_EX_FORWARDING_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   logic                    valid_q, valid_d;
   ctrl_t                   ctrl_q, ctrl_d;
   logic [REG_ADDR_LEN-1:0] rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
   logic [WORD_LEN-1:0]     reg1_q, reg1_d, reg2_q, reg2_d, imm_q, imm_d;
   logic [WORD_LEN-1:0]     rs_fwd, rt_fwd, reg1_hold, reg2_hold;

   // A WB write retiring while ID is stalled would otherwise never reach the
   // held operands, since the register-file read already happened.
   assign reg1_hold = (FWD_EN && wb_wb_en && (rs_q != '0) && (wb_dest == rs_q))
                      ? wb_value : reg1_q;
   assign reg2_hold = (FWD_EN && wb_wb_en && (rt_q != '0) && (wb_dest == rt_q))
                      ? wb_value : reg2_q;

   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      dest_d  = dest_q;
      reg1_d  = reg1_q;
      reg2_d  = reg2_q;
      imm_d   = imm_q;
      if (flush) begin
         valid_d = 1'b0;
         ctrl_d  = CTRL_NOP;
         rs_d    = '0;
         rt_d    = '0;
         dest_d  = '0;
         reg1_d  = '0;
         reg2_d  = '0;
         imm_d   = '0;
      end else if (stall) begin
         reg1_d = reg1_hold;
         reg2_d = reg2_hold;
      end else begin
         valid_d            = id_valid;
         ctrl_d.alu_cmd     = id_alu_cmd;
         ctrl_d.alu_src_imm = id_alu_src_imm;
         ctrl_d.mem_read    = id_valid & id_mem_read;
         ctrl_d.mem_write   = id_valid & id_mem_write;
         ctrl_d.wb_en       = id_valid & id_wb_en;
         rs_d               = id_rs;
         rt_d               = id_rt;
         dest_d             = id_dest;
         reg1_d             = id_reg1_data;
         reg2_d             = id_reg2_data;
         imm_d              = id_imm;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         ctrl_q  <= CTRL_NOP;
         rs_q    <= '0;
         rt_q    <= '0;
         dest_q  <= '0;
         reg1_q  <= '0;
         reg2_q  <= '0;
         imm_q   <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         dest_q  <= dest_d;
         reg1_q  <= reg1_d;
         reg2_q  <= reg2_d;
         imm_q   <= imm_d;
      end
   end

   id_ex_stage_fwd_mux #(
      .WORD_LEN(WORD_LEN), .REG_ADDR_LEN(REG_ADDR_LEN), .FWD_EN(FWD_EN)
   ) u_fwd_rs (
      .src_idx(rs_q), .reg_val(reg1_q),
      .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_val(mem_alu_result),
      .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_val(wb_value),
      .fwd_val(rs_fwd)
   );

   id_ex_stage_fwd_mux #(
      .WORD_LEN(WORD_LEN), .REG_ADDR_LEN(REG_ADDR_LEN), .FWD_EN(FWD_EN)
   ) u_fwd_rt (
      .src_idx(rt_q), .reg_val(reg2_q),
      .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_val(mem_alu_result),
      .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_val(wb_value),
      .fwd_val(rt_fwd)
   );

   assign ex_valid      = valid_q;
   assign ex_alu_a      = rs_fwd;
   assign ex_alu_b      = ctrl_q.alu_src_imm ? imm_q : rt_fwd;
   assign ex_store_data = rt_fwd;
   assign ex_alu_cmd    = ctrl_q.alu_cmd;
   assign ex_dest       = dest_q;
   assign ex_mem_read   = valid_q & ctrl_q.mem_read;
   assign ex_mem_write  = valid_q & ctrl_q.mem_write;
   assign ex_wb_en      = valid_q & ctrl_q.wb_en;

`ifdef ID_EX_FORWARDING_EN
   assign load_use_hazard = ex_mem_read & (dest_q != '0) &
                            ((id_rs == dest_q) | (id_rt == dest_q));
`else
   // Without bypassing, any producer still in EX or MEM must stall its consumer.
   logic rs_raw, rt_raw;
   assign rs_raw = (id_rs != '0) & ((ex_wb_en & (id_rs == dest_q)) |
                                    (mem_wb_en & (id_rs == mem_dest)));
   assign rt_raw = (id_rt != '0) & ((ex_wb_en & (id_rt == dest_q)) |
                                    (mem_wb_en & (id_rt == mem_dest)));
   assign load_use_hazard = rs_raw | rt_raw;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Scoreboard bench for id_ex_stage; expectations follow whichever
//            build of ID_EX_FORWARDING_EN is compiled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

`ifdef ID_EX_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam int VW = 109;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic        id_valid, id_alu_src_imm, id_mem_read, id_mem_write, id_wb_en;
   logic [31:0] id_reg1_data, id_reg2_data, id_imm;
   logic [4:0]  id_rs, id_rt, id_dest;
   logic [2:0]  id_alu_cmd;
   logic        mem_wb_en, wb_wb_en;
   logic [4:0]  mem_dest, wb_dest;
   logic [31:0] mem_alu_result, wb_value;
   logic        ex_valid, ex_mem_read, ex_mem_write, ex_wb_en, load_use_hazard;
   logic [31:0] ex_alu_a, ex_alu_b, ex_store_data;
   logic [2:0]  ex_alu_cmd;
   logic [4:0]  ex_dest;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_reg1_data(id_reg1_data), .id_reg2_data(id_reg2_data),
      .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
      .id_alu_cmd(id_alu_cmd), .id_alu_src_imm(id_alu_src_imm),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_wb_en(id_wb_en),
      .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_alu_result(mem_alu_result),
      .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
      .ex_valid(ex_valid), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
      .ex_alu_cmd(ex_alu_cmd), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_wb_en(ex_wb_en),
      .load_use_hazard(load_use_hazard)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [VW-1:0] exp_q[$];
   logic [VW-1:0] obs, e;

   assign obs = {ex_valid, ex_alu_a, ex_alu_b, ex_alu_cmd, ex_store_data, ex_dest,
                 ex_mem_read, ex_mem_write, ex_wb_en, load_use_hazard};

   function automatic logic [VW-1:0] ev(input logic v, input logic [31:0] a,
      input logic [31:0] b, input logic [2:0] cmd, input logic [31:0] st,
      input logic [4:0] d, input logic mr, input logic mw, input logic wb,
      input logic lu);
      return {v, a, b, cmd, st, d, mr, mw, wb, lu};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_id();
      id_valid = 0; id_reg1_data = 0; id_reg2_data = 0; id_imm = 0;
      id_rs = 0; id_rt = 0; id_dest = 0; id_alu_cmd = 0;
      id_alu_src_imm = 0; id_mem_read = 0; id_mem_write = 0; id_wb_en = 0;
   endtask

   task automatic load_id(input logic v, input logic [31:0] r1, input logic [31:0] r2,
      input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] dst, input logic [2:0] cmd, input logic si,
      input logic mr, input logic mw, input logic wb);
      id_valid = v; id_reg1_data = r1; id_reg2_data = r2; id_imm = imm;
      id_rs = rs; id_rt = rt; id_dest = dst; id_alu_cmd = cmd;
      id_alu_src_imm = si; id_mem_read = mr; id_mem_write = mw; id_wb_en = wb;
   endtask

   task automatic set_mem(input logic en, input logic [4:0] d, input logic [31:0] v);
      mem_wb_en = en; mem_dest = d; mem_alu_result = v;
   endtask

   task automatic set_wb(input logic en, input logic [4:0] d, input logic [31:0] v);
      wb_wb_en = en; wb_dest = d; wb_value = v;
   endtask

   task automatic test_reset();
      rst = 1; stall = 0; flush = 0;
      set_mem(0, 0, 0); set_wb(0, 0, 0);
      load_id(1, 32'h5, 32'h7, 32'h9, 5'd1, 5'd2, 5'd3, 3'd1, 1, 1, 1, 1);
      exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 2; i++) begin
         tick();
         e = exp_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL reset_c%0d got %h exp %h", i, obs, e);
         end
      end
      rst = 0;
      idle_id();
   endtask

   task automatic test_load();
      load_id(1, 32'h5, 32'h7, 32'h99, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 0, 1);
      exp_q.push_back(ev(1, 32'h5, 32'h7, 3'd0, 32'h7, 5'd3, 0, 0, 1, 0));
      tick(); idle_id(); #1;
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL load_add got %h exp %h", obs, e); end

      load_id(1, 32'h11, 32'h22, 32'h99, 5'd1, 5'd2, 5'd3, 3'd1, 1, 0, 1, 0);
      exp_q.push_back(ev(1, 32'h11, 32'h99, 3'd1, 32'h22, 5'd3, 0, 1, 0, 0));
      tick(); idle_id(); #1;
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL load_imm_sw got %h exp %h", obs, e); end

      load_id(0, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 3'd2, 0, 1, 1, 1);
      tick(); idle_id(); #1;
      n_vec++;
      if ({ex_valid, ex_mem_read, ex_mem_write, ex_wb_en} !== 4'b0000) begin
         n_err++;
         $display("FAIL load_bubble got %b exp 0000",
                  {ex_valid, ex_mem_read, ex_mem_write, ex_wb_en});
      end
   endtask

   task automatic test_forwarding();
      load_id(1, 32'h11, 32'h22, 32'h0, 5'd4, 5'd5, 5'd6, 3'd3, 0, 0, 0, 1);
      tick(); idle_id();
      set_mem(1, 5'd4, 32'h10); set_wb(1, 5'd4, 32'h20);
      exp_q.push_back(ev(1, FWD ? 32'h10 : 32'h11, 32'h22, 3'd3, 32'h22, 5'd6, 0, 0, 1, 0));
      #1; e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL fwd_mem_prio got %h exp %h", obs, e); end

      mem_wb_en = 0;
      exp_q.push_back(ev(1, FWD ? 32'h20 : 32'h11, 32'h22, 3'd3, 32'h22, 5'd6, 0, 0, 1, 0));
      #1; e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL fwd_wb got %h exp %h", obs, e); end

      set_mem(1, 5'd5, 32'h30); set_wb(0, 0, 0);
      exp_q.push_back(ev(1, 32'h11, FWD ? 32'h30 : 32'h22, 3'd3, FWD ? 32'h30 : 32'h22,
                         5'd6, 0, 0, 1, 0));
      #1; e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL fwd_rt got %h exp %h", obs, e); end

      set_mem(0, 0, 0);
      load_id(1, 32'h77, 32'h66, 32'h0, 5'd0, 5'd0, 5'd7, 3'd0, 0, 0, 0, 1);
      tick(); idle_id();
      set_mem(1, 5'd0, 32'h10); set_wb(1, 5'd0, 32'h20);
      exp_q.push_back(ev(1, 32'h77, 32'h66, 3'd0, 32'h66, 5'd7, 0, 0, 1, 0));
      #1; e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL fwd_r0 got %h exp %h", obs, e); end
      set_mem(0, 0, 0); set_wb(0, 0, 0);
   endtask

   task automatic test_load_use();
      load_id(1, 32'h100, 32'h200, 32'h4, 5'd1, 5'd2, 5'd8, 3'd0, 1, 1, 0, 1);
      tick(); idle_id();
      id_rs = 5'd9; id_rt = 5'd8;
      exp_q.push_back(ev(1, 32'h100, 32'h4, 3'd0, 32'h200, 5'd8, 1, 0, 1, 1));
      #1; e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL lu_rt got %h exp %h", obs, e); end

      id_rt = 5'd7;
      exp_q.push_back(ev(1, 32'h100, 32'h4, 3'd0, 32'h200, 5'd8, 1, 0, 1, 0));
      #1; e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL lu_nomatch got %h exp %h", obs, e); end

      id_rs = 5'd8; id_rt = 5'd0;
      exp_q.push_back(ev(1, 32'h100, 32'h4, 3'd0, 32'h200, 5'd8, 1, 0, 1, 1));
      #1; e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL lu_rs got %h exp %h", obs, e); end

      load_id(1, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd10, 3'd0, 0, 0, 0, 1);
      tick(); idle_id();
      id_rs = 5'd10;
      exp_q.push_back(ev(1, 32'h1, 32'h2, 3'd0, 32'h2, 5'd10, 0, 0, 1, !FWD));
      #1; e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL raw_alu_ex got %h exp %h", obs, e); end

      id_rs = 5'd12; set_mem(1, 5'd12, 32'h5);
      exp_q.push_back(ev(1, 32'h1, 32'h2, 3'd0, 32'h2, 5'd10, 0, 0, 1, !FWD));
      #1; e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL raw_mem got %h exp %h", obs, e); end
      set_mem(0, 0, 0);

      load_id(1, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd0, 3'd0, 0, 1, 0, 1);
      tick(); idle_id();
      exp_q.push_back(ev(1, 32'h1, 32'h2, 3'd0, 32'h2, 5'd0, 1, 0, 1, 0));
      #1; e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL lu_dest0 got %h exp %h", obs, e); end
   endtask

   task automatic test_stall_refresh();
      load_id(1, 32'h11, 32'h22, 32'h0, 5'd4, 5'd5, 5'd6, 3'd2, 0, 0, 0, 1);
      tick();
      stall = 1;
      load_id(1, 32'hdead, 32'hbeef, 32'h1, 5'd7, 5'd7, 5'd9, 3'd1, 1, 1, 1, 0);
      set_wb(1, 5'd4, 32'h55);
      exp_q.push_back(ev(1, FWD ? 32'h55 : 32'h11, 32'h22, 3'd2, 32'h22, 5'd6, 0, 0, 1, 0));
      #1; e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL stall_live got %h exp %h", obs, e); end

      for (int c = 1; c <= 2; c++) begin
         tick();
         set_wb(0, 0, 0);
         exp_q.push_back(ev(1, FWD ? 32'h55 : 32'h11, 32'h22, 3'd2, 32'h22, 5'd6, 0, 0, 1, 0));
         #1; e = exp_q.pop_front(); n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL stall_c%0d got %h exp %h", c, obs, e);
         end
      end
      stall = 0; idle_id();
      tick();
   endtask

   task automatic test_flush_stall();
      load_id(1, 32'h3, 32'h4, 32'h0, 5'd1, 5'd2, 5'd5, 3'd0, 0, 0, 1, 1);
      tick();
      flush = 1; stall = 1;
      exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick(); flush = 0; stall = 0; idle_id(); #1;
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL flush_over_stall got %h exp %h", obs, e); end

      load_id(1, 32'h3, 32'h4, 32'h0, 5'd1, 5'd2, 5'd5, 3'd4, 1, 1, 0, 1);
      tick();
      stall = 1; rst = 1;
      exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick(); rst = 0; stall = 0; idle_id(); #1;
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL rst_mid_stall got %h exp %h", obs, e); end
   endtask

   task automatic test_back_to_back();
      localparam int N = 8;
      logic [31:0] r1[N], r2[N], imm[N];
      logic [4:0]  rs[N], rt[N], dst[N];
      logic [2:0]  cmd[N];
      logic        si[N], mr[N], wb[N];
      logic [4:0]  nrs, nrt;
      logic        lu;
      for (int i = 0; i < N; i++) begin
         r1[i] = $urandom; r2[i] = $urandom; imm[i] = $urandom;
         rs[i] = 5'($urandom_range(0, 3)); rt[i] = 5'($urandom_range(0, 3));
         dst[i] = 5'($urandom_range(0, 3)); cmd[i] = 3'($urandom_range(0, 4));
         si[i] = 1'($urandom_range(0, 1)); mr[i] = 1'($urandom_range(0, 1));
         wb[i] = 1'($urandom_range(0, 1));
      end
      load_id(1, r1[0], r2[0], imm[0], rs[0], rt[0], dst[0], cmd[0], si[0], mr[0], 0, wb[0]);
      tick();
      for (int i = 0; i < N; i++) begin
         if (i < N - 1) begin
            load_id(1, r1[i+1], r2[i+1], imm[i+1], rs[i+1], rt[i+1], dst[i+1],
                    cmd[i+1], si[i+1], mr[i+1], 0, wb[i+1]);
            nrs = rs[i+1]; nrt = rt[i+1];
         end else begin
            idle_id();
            nrs = 0; nrt = 0;
         end
         if (FWD)
            lu = mr[i] && (dst[i] != 0) && ((nrs == dst[i]) || (nrt == dst[i]));
         else
            lu = wb[i] && (((nrs != 0) && (nrs == dst[i])) || ((nrt != 0) && (nrt == dst[i])));
         exp_q.push_back(ev(1, r1[i], si[i] ? imm[i] : r2[i], cmd[i], r2[i], dst[i],
                            mr[i], 0, wb[i], lu));
         #1; e = exp_q.pop_front(); n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL b2b_%0d got %h exp %h", i, obs, e);
         end
         if (i < N - 1) tick();
      end
      idle_id();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_load();
      test_forwarding();
      test_load_use();
      test_stall_refresh();
      test_flush_stall();
      test_back_to_back();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain got %0d exp 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
